// File: rtl/m_illegaltrap_pkg.sv
// rtl/m_illegaltrap_pkg.sv - shared opcodes, FSM encoding and decode-mode constants
package m_illegaltrap_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int LAZY_FULL  = 0;
    localparam int LAZY_MAJOR = 1;
    localparam int LAZY_BIT0  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_TRAP  = 2'd2
    } state_e;

endpackage

// File: rtl/m_illegaltrap_dec.sv
// rtl/m_illegaltrap_dec.sv - combinational RV32I(M) illegal-instruction decoder
module m_illegaldec
    import m_illegaltrap_pkg::*;
#(
    parameter int LAZY_DECODE = 0,
    parameter int MULDIV      = 0
) (
    input  logic [31:0] instr,
    input  logic        corerunning,
    output logic        illegal
);

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       main_illegal;
    logic       ext_illegal;

    assign opcode = instr[6:2];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];

    always_comb begin
        main_illegal = (instr[1:0] != 2'b11);
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: ;
            default: main_illegal = 1'b1;
        endcase
    end

    // funct7 only qualifies shift-immediates on OP-IMM; elsewhere those bits are immediate.
    always_comb begin
        ext_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (!((funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                      ((MULDIV != 0) && (funct7 == F7_MULDIV))))
                    ext_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                if ((funct3 == 3'b001) && (funct7 != F7_ZERO))
                    ext_illegal = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT))
                    ext_illegal = 1'b1;
            end
            OPC_LOAD:     ext_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OPC_STORE:    ext_illegal = funct3[2] || (funct3 == 3'b011);
            OPC_BRANCH:   ext_illegal = (funct3[2:1] == 2'b01);
            OPC_JALR:     ext_illegal = (funct3 != 3'b000);
            OPC_MISC_MEM: ext_illegal = (funct3[2:1] != 2'b00);
            OPC_SYSTEM: begin
                if (funct3 == 3'b100)
                    ext_illegal = 1'b1;
                if ((funct3[1:0] == 2'b00) && ((rs1 != 5'd0) || (rd != 5'd0)))
                    ext_illegal = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (LAZY_DECODE == LAZY_FULL)
            illegal = (main_illegal | ext_illegal) & corerunning;
        else if (LAZY_DECODE == LAZY_MAJOR)
            illegal = main_illegal & corerunning;
        else
            illegal = ~instr[0] & corerunning;
    end

endmodule

// File: rtl/m_illegaltrap.sv
// rtl/m_illegaltrap.sv - instruction legality check with held trap request and event counter
module m_illegaltrap
    import m_illegaltrap_pkg::*;
#(
    parameter int LAZY_DECODE = 0,
    parameter int MULDIV      = 0,
    parameter int XLEN        = 32,
    parameter int CNTW        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            corerunning,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            instr_ready,
    output logic            ok_pulse,
    output logic            trap_req,
    input  logic            trap_ack,
    output logic [31:0]     trap_mtval,
    output logic [XLEN-1:0] trap_mepc,
    output logic [CNTW-1:0] illcnt,
    input  logic            cnt_clr
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     mtval_q, mtval_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            illegal;

    m_illegaldec #(
        .LAZY_DECODE (LAZY_DECODE),
        .MULDIV      (MULDIV)
    ) u_dec (
        .instr       (instr_q),
        .corerunning (corerunning),
        .illegal     (illegal)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        mtval_d = mtval_q;
        mepc_d  = mepc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    pc_d    = pc;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                    mtval_d = instr_q;
                    mepc_d  = pc_q;
                    if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + CNTW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP: begin
                if (trap_ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear has priority over a same-edge increment.
        if (cnt_clr)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            mtval_q <= '0;
            mepc_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            mtval_q <= mtval_d;
            mepc_q  <= mepc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE) & rst_n;
    assign ok_pulse    = (state_q == ST_CHECK) & ~illegal;
    assign trap_req    = (state_q == ST_TRAP);
    assign trap_mtval  = mtval_q;
    assign trap_mepc   = mepc_q;
    assign illcnt      = cnt_q;

endmodule

// File: tb/tb_m_illegaltrap.sv
// tb/tb_m_illegaltrap.sv - five parameter variants driven in lockstep against a reference model
module tb_m_illegaltrap;

    localparam int LZ[5]   = '{0, 0, 1, 2, 0};
    localparam int MD[5]   = '{0, 1, 0, 0, 0};
    localparam int CMAX[5] = '{255, 255, 255, 255, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        corerunning = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        trap_ack = 1'b0;
    logic        cnt_clr = 1'b0;

    logic [4:0]  rdy, ok, trq;
    logic [31:0] mtval [5];
    logic [31:0] mepc [5];
    logic [7:0]  cnt_w [5];
    logic [1:0]  cnt4;

    int checks = 0;
    int failures = 0;
    int mcnt [5];

    assign cnt_w[4] = {6'd0, cnt4};

    always #5 clk = ~clk;

    m_illegaltrap #(.LAZY_DECODE(0), .MULDIV(0), .XLEN(32), .CNTW(8)) d0 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .instr_ready(rdy[0]), .ok_pulse(ok[0]), .trap_req(trq[0]),
        .trap_ack(trap_ack), .trap_mtval(mtval[0]), .trap_mepc(mepc[0]), .illcnt(cnt_w[0]),
        .cnt_clr(cnt_clr));
    m_illegaltrap #(.LAZY_DECODE(0), .MULDIV(1), .XLEN(32), .CNTW(8)) d1 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .instr_ready(rdy[1]), .ok_pulse(ok[1]), .trap_req(trq[1]),
        .trap_ack(trap_ack), .trap_mtval(mtval[1]), .trap_mepc(mepc[1]), .illcnt(cnt_w[1]),
        .cnt_clr(cnt_clr));
    m_illegaltrap #(.LAZY_DECODE(1), .MULDIV(0), .XLEN(32), .CNTW(8)) d2 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .instr_ready(rdy[2]), .ok_pulse(ok[2]), .trap_req(trq[2]),
        .trap_ack(trap_ack), .trap_mtval(mtval[2]), .trap_mepc(mepc[2]), .illcnt(cnt_w[2]),
        .cnt_clr(cnt_clr));
    m_illegaltrap #(.LAZY_DECODE(2), .MULDIV(0), .XLEN(32), .CNTW(8)) d3 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .instr_ready(rdy[3]), .ok_pulse(ok[3]), .trap_req(trq[3]),
        .trap_ack(trap_ack), .trap_mtval(mtval[3]), .trap_mepc(mepc[3]), .illcnt(cnt_w[3]),
        .cnt_clr(cnt_clr));
    m_illegaltrap #(.LAZY_DECODE(0), .MULDIV(0), .XLEN(32), .CNTW(2)) d4 (
        .clk(clk), .rst_n(rst_n), .corerunning(corerunning), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .instr_ready(rdy[4]), .ok_pulse(ok[4]), .trap_req(trq[4]),
        .trap_ack(trap_ack), .trap_mtval(mtval[4]), .trap_mepc(mepc[4]), .illcnt(cnt4),
        .cnt_clr(cnt_clr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Legal funct3 values per major opcode, one bit per funct3 value.
    function automatic bit ref_illegal(input bit [31:0] w, input bit cr, input int lazy, input int md);
        bit [4:0] op = w[6:2];
        bit [2:0] f3 = w[14:12];
        bit [6:0] f7 = w[31:25];
        bit [7:0] legal_f3;
        if (!cr) return 1'b0;
        if (lazy == 2) return !w[0];
        if (w[1:0] != 2'b11) return 1'b1;
        if (!(op inside {5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C}))
            return 1'b1;
        if (lazy == 1) return 1'b0;
        legal_f3 = 8'hFF;
        case (op)
            5'h00: legal_f3 = 8'b0011_0111;
            5'h08: legal_f3 = 8'b0000_0111;
            5'h18: legal_f3 = 8'b1111_0011;
            5'h19: legal_f3 = 8'b0000_0001;
            5'h03: legal_f3 = 8'b0000_0011;
            5'h1C: legal_f3 = 8'b1110_1111;
            default: ;
        endcase
        if (!legal_f3[f3]) return 1'b1;
        if (op == 5'h1C && f3 == 3'd0 && (w[11:7] != 0 || w[19:15] != 0)) return 1'b1;
        if (op == 5'h0C)
            return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (md == 1 && f7 == 7'h01));
        if (op == 5'h04 && f3 == 3'd1) return f7 != 7'h00;
        if (op == 5'h04 && f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        bit [4:0] ops[11] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            w[1:0] = 2'b11;
            w[6:2] = ops[$urandom_range(0, 10)];
        end
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            w[11:7]  = 5'd0;
            w[19:15] = 5'd0;
        end
        return w;
    endfunction

    // Starts and ends on a falling edge: accept, CHECK, TRAP-or-IDLE, acknowledge.
    task automatic txn(input logic [31:0] w, input logic [31:0] a, input logic cr, input logic clr);
        bit ill [5];
        for (int i = 0; i < 5; i++) ill[i] = ref_illegal(w, cr, LZ[i], MD[i]);
        instr_valid = 1'b1;
        instr = w;
        pc = a;
        corerunning = cr;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        cnt_clr = clr;
        chk("busy_in_check", 32'(rdy), 32'h0);
        for (int i = 0; i < 5; i++) chk($sformatf("ok%0d", i), 32'(ok[i]), 32'(!ill[i]));
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (clr) mcnt[i] = 0;
            else if (ill[i] && mcnt[i] < CMAX[i]) mcnt[i]++;
            chk($sformatf("trap_req%0d", i), 32'(trq[i]), 32'(ill[i]));
            chk($sformatf("illcnt%0d", i), 32'(cnt_w[i]), 32'(mcnt[i]));
            if (ill[i]) begin
                chk($sformatf("mtval%0d", i), mtval[i], w);
                chk($sformatf("mepc%0d", i), mepc[i], a);
            end
        end
        trap_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trap_ack = 1'b0;
        chk("trap_cleared", 32'(trq), 32'h0);
        chk("ready_after", 32'(rdy), 32'h1F);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_trap_req", 32'(trq), 32'h0);
        chk("rst_ok", 32'(ok), 32'h0);
        chk("rst_cnt0", 32'(cnt_w[0]), 32'h0);
        chk("rst_mtval0", mtval[0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_post_rst", 32'(rdy), 32'h1F);

        txn(32'h003100B3, 32'h0000_0040, 1'b1, 1'b0);
        txn(32'h023100B3, 32'h0000_0100, 1'b1, 1'b0);
        txn(32'h000000F3, 32'h0000_0104, 1'b1, 1'b0);
        txn(32'h00000073, 32'h0000_0108, 1'b1, 1'b0);
        txn(32'h00000001, 32'h0000_010C, 1'b1, 1'b0);
        txn(32'h00000000, 32'h0000_0110, 1'b0, 1'b0);
        txn(32'h4010D093, 32'h0000_0114, 1'b1, 1'b0);
        txn(32'h4010C093, 32'h0000_0118, 1'b1, 1'b0);

        for (int k = 0; k < 5; k++) txn(32'h00000000, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
        chk("sat_cnt4", 32'(cnt4), 32'd3);
        txn(32'h00000000, 32'h0000_0300, 1'b1, 1'b1);
        chk("clr_wins_cnt4", 32'(cnt4), 32'd0);

        for (int k = 0; k < 150; k++)
            txn(rand_instr(), $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));

        instr_valid = 1'b1;
        instr = 32'h023100B3;
        pc = 32'h0000_0500;
        corerunning = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_trap0", 32'(trq[0]), 32'h1);
        corerunning = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("trap_held_cr0", 32'(trq[0]), 32'h1);
        chk("mtval_stable0", mtval[0], 32'h023100B3);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        chk("rst_trap_gone", 32'(trq), 32'h0);
        chk("rst_cnt_zero0", 32'(cnt_w[0]), 32'h0);
        chk("rst_mepc0", mepc[0], 32'h0);
        chk("rst_ready_low", 32'(rdy), 32'h0);
        rst_n = 1'b1;
        corerunning = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy), 32'h1F);
        txn(32'h003100B3, 32'h0000_0600, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_illegaltrap.md
M_ILLEGALTRAP -- requirements
Module: m_illegaltrap

Interface
REQ-001 Parameter LAZY_DECODE, default 0: 0 = full decode, 1 = major-opcode decode only, 2 = check INSTR[0] only.
REQ-002 Parameter MULDIV, default 0: 1 = RV32M encodings legal.
REQ-003 Parameter XLEN, default 32: PC width.
REQ-004 Parameter CNTW, default 8: illegal-event counter width, 1..32.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 corerunning  in  1  0 = all instructions treated as legal.
REQ-008 instr_valid  in  1  instruction offered.
REQ-009 instr  in  32  instruction word.
REQ-010 pc  in  XLEN  address of instr.
REQ-011 instr_ready  out  1  block can accept an instruction.
REQ-012 ok_pulse  out  1  one-cycle pulse: accepted instruction is legal.
REQ-013 trap_req  out  1  illegal-instruction trap request, held until acknowledged.
REQ-014 trap_ack  in  1  core accepts the trap.
REQ-015 trap_mtval  out  32  offending instruction word.
REQ-016 trap_mepc  out  XLEN  PC of the offending instruction.
REQ-017 illcnt  out  CNTW  saturating count of trapped instructions.
REQ-018 cnt_clr  in  1  synchronous clear of illcnt.

Function
REQ-019 FSM states: IDLE, CHECK, TRAP; instr_ready SHALL be 1 only in IDLE.
REQ-020 IDLE with instr_valid=1: register instr and pc, go to CHECK; with instr_valid=0, stay in IDLE.
REQ-021 CHECK lasts exactly one cycle; the decoder evaluates the registered instruction.
REQ-022 CHECK, not illegal: ok_pulse=1 for that cycle, go to IDLE; accept-to-ok latency is 1 cycle; throughput is 1 instruction per 2 cycles.
REQ-023 CHECK, illegal: go to TRAP, load trap_mtval/trap_mepc, and increment illcnt on that edge.
REQ-024 TRAP: trap_req=1, and trap_mtval/trap_mepc SHALL stay stable; trap_ack=1 returns to IDLE on that edge, so trap_req falls the next cycle.
REQ-025 trap_ack outside TRAP SHALL be ignored.
REQ-026 illegal = (main_illegal | ext_illegal) & corerunning, sampled in CHECK; corerunning falling during TRAP does not cancel the trap.
REQ-027 main_illegal SHALL be 1 when INSTR[1:0] != 2'b11.
REQ-028 main_illegal SHALL be 1 when INSTR[6:2] is not one of: LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM.
REQ-029 ext_illegal (LAZY_DECODE=0 only) SHALL flag:
 - funct7 != 0 for OP/OP-IMM, except funct7=0100000 on add/sub, srl/sra, srai;
 - funct7=0000001 on OP when MULDIV=1;
 - reserved funct3 for LOAD, STORE, BRANCH, JALR, MISC-MEM;
 - SYSTEM funct3=100;
 - SYSTEM funct3[1:0]=00 with rs1 != 0 or rd != 0.
REQ-030 LAZY_DECODE=1: illegal = main_illegal & corerunning.
REQ-031 LAZY_DECODE=2: illegal = ~instr[0] & corerunning.
REQ-032 illcnt SHALL saturate at 2^CNTW-1.
REQ-033 cnt_clr concurrent with an increment: clear wins, illcnt=0.

Reset
REQ-034 rst_n=0 at an edge, in any state including TRAP, SHALL force: state IDLE; ok_pulse=0, trap_req=0, trap_mtval=0, trap_mepc=0, illcnt=0.
REQ-035 instr_ready=0 while rst_n=0; instr_ready=1 from the first cycle after rst_n=1.
REQ-036 A pending trap is discarded by reset, with no trap_ack required.

Structure
REQ-037 Shared package holds: opcode constants (LOAD..SYSTEM, 5-bit), the FSM state encoding, and LAZY_DECODE mode constants.
REQ-038 Decode is one combinational sub-module m_illegaldec (instr, corerunning, illegal), parameterised by LAZY_DECODE and MULDIV; m_illegaltrap holds all registers.

Verification
REQ-039 MULDIV=0, LAZY 0: instr=0x003100B3 (add) -> ok_pulse 1 cycle after accept, trap_req=0, illcnt=0.
REQ-040 MULDIV=0, instr=0x023100B3 (mul), pc=0x100 -> trap_req=1, trap_mtval=0x023100B3, trap_mepc=0x100, illcnt=1; with MULDIV=1 -> ok_pulse instead.
REQ-041 LAZY 0: 0x000000F3 (ecall, rd=1) -> trap; LAZY 1 -> ok_pulse; instr=0x00000001 with LAZY 2 -> ok_pulse, with LAZY 1 -> trap.
REQ-042 corerunning=0, instr=0x00000000 -> ok_pulse, illcnt unchanged.
REQ-043 CNTW=2: five illegal instructions -> illcnt=3; cnt_clr with a sixth trap in the same cycle -> illcnt=0.
REQ-044 rst_n=0 during TRAP without trap_ack -> next cycle trap_req=0, illcnt=0; instr_ready=1 once rst_n=1.
